// File: rtl/dev_io_uart.sv
// rtl/dev_io_uart.sv - character I/O device: TX FIFO + UART 8N1 serializer, RX FIFO with getc interface.
// Optional DEV_IO_UART_ECHO_EN: every byte accepted into the RX FIFO is also queued for transmit.
module dev_io_uart #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       putc_push,
  input  logic [7:0] putc_char,
  input  logic       getc_pop,
  output logic       getc_en,
  output logic [7:0] getc_char,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [PW-1:0] tx_wptr_q, tx_rptr_q;
  logic [CW-1:0] tx_cnt_q;
  logic          ovf_q;

  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [PW-1:0] rx_wptr_q, rx_rptr_q;
  logic [CW-1:0] rx_cnt_q;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          tx_pop;

  logic          rx_wr, rx_pop;
  logic          put_wr, echo_req, echo_wr;
  logic [CW:0]   tx_free;

  assign rx_ready  = (rx_cnt_q != DEPTH_C);
  assign getc_en   = (rx_cnt_q != '0);
  assign getc_char = getc_en ? rx_mem_q[rx_rptr_q] : 8'h00;
  assign rx_wr     = rx_valid && rx_ready;
  assign rx_pop    = getc_pop && getc_en;

`ifdef DEV_IO_UART_ECHO_EN
  assign echo_req = rx_wr;
`else
  assign echo_req = 1'b0;
`endif

  // Slots available this cycle, counting the one the serializer frees by popping.
  assign tx_free = {1'b0, DEPTH_C} - {1'b0, tx_cnt_q} + {{CW{1'b0}}, tx_pop};
  assign put_wr  = putc_push && (tx_free != '0);
  assign echo_wr = echo_req && (tx_free > (CW+1)'(put_wr));

  assign tx       = tx_q;
  assign tx_busy  = (state_q != IDLE) || (tx_cnt_q != '0);
  assign overflow = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) tx_mem_q[i] <= 8'h00;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (put_wr) tx_mem_q[tx_wptr_q] <= putc_char;
      if (echo_wr) tx_mem_q[tx_wptr_q + PW'(put_wr)] <= rx_data;
      tx_wptr_q <= tx_wptr_q + PW'(put_wr) + PW'(echo_wr);
      tx_rptr_q <= tx_rptr_q + PW'(tx_pop);
      tx_cnt_q  <= tx_cnt_q + CW'(put_wr) + CW'(echo_wr) - CW'(tx_pop);
      if ((putc_push && !put_wr) || (echo_req && !echo_wr)) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) rx_mem_q[i] <= 8'h00;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (rx_wr) rx_mem_q[rx_wptr_q] <= rx_data;
      rx_wptr_q <= rx_wptr_q + PW'(rx_wr);
      rx_rptr_q <= rx_rptr_q + PW'(rx_pop);
      rx_cnt_q  <= rx_cnt_q + CW'(rx_wr) - CW'(rx_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (tx_cnt_q != '0) begin
          tx_pop  = 1'b1;
          shift_d = tx_mem_q[tx_rptr_q];
          state_d = START;
        end
      end
      START: begin
        if (baud_q == BAUD_MAX) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_q == BAUD_MAX) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else bit_d = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (baud_q == BAUD_MAX) begin
          baud_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Line level follows the next state so tx lines up with the state register.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_dev_io_uart.sv
// tb/tb_dev_io_uart.sv - scoreboard bench for dev_io_uart (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_dev_io_uart;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       putc_push;
  logic [7:0] putc_char;
  logic       getc_pop;
  logic       getc_en;
  logic [7:0] getc_char;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx;
  logic       tx_busy;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic [9:0] frame41;

  always #5 clk = ~clk;

  dev_io_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .putc_push(putc_push), .putc_char(putc_char),
    .getc_pop(getc_pop), .getc_en(getc_en), .getc_char(getc_char),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx(tx), .tx_busy(tx_busy), .overflow(overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // UART line monitor: decodes frames mid-bit and checks against the TX scoreboard.
  logic       mon_act = 1'b0;
  int         mcnt = 0;
  logic [7:0] mbyte = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (tx === 1'b0) begin
        mon_act = 1'b1;
        mcnt    = 0;
      end
    end else begin
      mcnt++;
      if (mcnt % CPB == CPB / 2) begin
        if (mcnt / CPB == 0) check("tx_start_bit", {31'd0, tx}, 32'd0);
        else if (mcnt / CPB <= 8) mbyte[mcnt / CPB - 1] = tx;
        else begin
          check("tx_stop_bit", {31'd0, tx}, 32'd1);
          if (tx_exp.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL tx_unexpected_frame: got 0x%0h expected none", mbyte);
          end else begin
            check("tx_byte", {24'd0, mbyte}, {24'd0, tx_exp.pop_front()});
          end
          mon_act = 1'b0;
        end
      end
    end
  end

  // getc monitor: every accepted pop must consume the next expected RX byte.
  always @(negedge clk) begin
    if (!rst && getc_pop && getc_en) begin
      if (rx_exp.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL getc_unexpected_pop: got 0x%0h expected none", getc_char);
      end else begin
        check("getc_pop_byte", {24'd0, getc_char}, {24'd0, rx_exp.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_put(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pop();
    getc_pop = 1'b1;
    tick();
    getc_pop = 1'b0;
  endtask

  task automatic wait_tx_idle();
    for (int i = 0; i < 2000; i++) begin
      if (!tx_busy) break;
      tick();
    end
    check("tx_drain_bound", {31'd0, tx_busy}, 32'd0);
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    frame41   = {1'b1, 8'h41, 1'b0};
    rst       = 1'b1;
    putc_push = 1'b0;
    putc_char = 8'h00;
    getc_pop  = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    tick();
    tick();
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_getc_en", {31'd0, getc_en}, 32'd0);
    check("rst_getc_char", {24'd0, getc_char}, 32'd0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    rst = 1'b0;
    tick();
    tick();

    // Single byte with exact cycle-level line check
    putc_push = 1'b1;
    putc_char = 8'h41;
    tx_exp.push_back(8'h41);
    tick();
    putc_push = 1'b0;
    check("push_busy", {31'd0, tx_busy}, 32'd1);
    check("push_tx_still_idle", {31'd0, tx}, 32'd1);
    for (int i = 0; i < 10 * CPB; i++) begin
      tick();
      check("tx_line_0x41", {31'd0, tx}, {31'd0, frame41[i / CPB]});
    end
    tick();
    check("busy_after_stop", {31'd0, tx_busy}, 32'd0);
    tick();

    // TX overflow: depth 4, six consecutive pushes, the sixth is dropped
    for (int i = 0; i < 6; i++) begin
      putc_push = 1'b1;
      putc_char = 8'h11 + 8'(i);
      if (i < 5) tx_exp.push_back(8'h11 + 8'(i));
      if (i == 5) check("overflow_before_6th", {31'd0, overflow}, 32'd0);
      tick();
    end
    putc_push = 1'b0;
    check("overflow_after_6th", {31'd0, overflow}, 32'd1);
    wait_tx_idle();
    check("overflow_sticky", {31'd0, overflow}, 32'd1);

    // RX / getc
    rx_valid = 1'b1;
    rx_data = 8'h10; rx_exp.push_back(8'h10); tick();
    rx_data = 8'h20; rx_exp.push_back(8'h20); tick();
    rx_data = 8'h30; rx_exp.push_back(8'h30); tick();
    rx_valid = 1'b0;
    check("getc_en_3", {31'd0, getc_en}, 32'd1);
    check("getc_head_10", {24'd0, getc_char}, 32'h10);
    pop();
    check("getc_head_20", {24'd0, getc_char}, 32'h20);
    pop();
    check("getc_head_30", {24'd0, getc_char}, 32'h30);
    pop();
    check("getc_en_empty", {31'd0, getc_en}, 32'd0);
    check("getc_char_empty", {24'd0, getc_char}, 32'h00);
    pop();
    check("getc_en_empty_pop", {31'd0, getc_en}, 32'd0);
    rx_put(8'h77);
    rx_exp.push_back(8'h77);
    check("getc_after_empty_pop", {24'd0, getc_char}, 32'h77);
    pop();

    // RX full: hold rx_valid six cycles, only four accepted
    rx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rx_data = 8'hA0 + 8'(i);
      if (i < 4) rx_exp.push_back(8'hA0 + 8'(i));
      tick();
    end
    check("rx_ready_full", {31'd0, rx_ready}, 32'd0);
    rx_data  = 8'hEE;
    getc_pop = 1'b1;
    tick();
    getc_pop = 1'b0;
    rx_valid = 1'b0;
    check("rx_ready_after_pop", {31'd0, rx_ready}, 32'd1);
    check("rx_head_after_full_pop", {24'd0, getc_char}, 32'hA1);
    pop();
    pop();
    pop();
    check("rx_drained", {31'd0, getc_en}, 32'd0);

    // Reset mid-frame
    rx_put(8'h99);
    putc_push = 1'b1;
    putc_char = 8'h3C;
    tick();
    putc_push = 1'b0;
    repeat (3 * CPB) tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_busy", {31'd0, tx_busy}, 32'd0);
    check("midrst_getc_en", {31'd0, getc_en}, 32'd0);
    check("midrst_getc_char", {24'd0, getc_char}, 32'd0);
    check("midrst_overflow", {31'd0, overflow}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    putc_push = 1'b1;
    putc_char = 8'hC3;
    tx_exp.push_back(8'hC3);
    tick();
    putc_push = 1'b0;
    wait_tx_idle();

`ifdef DEV_IO_UART_ECHO_EN
    rx_exp.push_back(8'h5A);
    tx_exp.push_back(8'h5A);
    rx_put(8'h5A);
    check("echo_getc_char", {24'd0, getc_char}, 32'h5A);
    wait_tx_idle();
    pop();
`endif

    repeat (4) tick();
    check("tx_scoreboard_empty", tx_exp.size(), 32'd0);
    check("rx_scoreboard_empty", rx_exp.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
